pipe_ctrl_unit: RTL

PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

---
 rtl/pipe_ctrl_unit.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl_unit.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_unit
// Pipeline control for a 5-stage RV32I-style core. It decodes the
// instruction in ID into a control bundle and carries that bundle through
// the ID/EX, EX/MEM and MEM/WB stage registers. It also detects load-use
// and control hazards and selects forwarding sources for the EX operands.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   id_valid          id_instr holds a real instruction
//   id_instr          instruction currently in ID
//   ex_branch_taken   branch condition resolved true in EX
//   stall             hold PC and IF/ID (load-use)
//   flush             squash IF/ID (taken branch or jump in EX)
//   id_illegal        opcode / funct3 in ID not supported
//   ex_*              ID/EX control fields seen by EX
//   fwd_a, fwd_b      EX operand source: 10 MEM, 01 WB, 00 register file
//   mem_memread/write EX/MEM access codes (101 / 11 mean no access)
//   wb_*              MEM/WB write-back controls
// ---------------------------------------------------------------------------
module pipe_ctrl_unit #(
    parameter bit ENABLE_JUMP = 1'b1,
    parameter int REG_AW      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    input  logic              ex_branch_taken,
    output logic              stall,
    output logic              flush,
    output logic              id_illegal,
    output logic              ex_alusrc,
    output logic [1:0]        ex_aluop,
    output logic              ex_branch,
    output logic              ex_jump,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [2:0]        mem_memread,
    output logic [1:0]        mem_memwrite,
    output logic              wb_regwrite,
    output logic              wb_memtoreg,
    output logic [REG_AW-1:0] wb_rd
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] MR_NONE = 3'b101;
    localparam logic [1:0] MW_NONE = 2'b11;

    typedef struct packed {
        logic              alusrc;
        logic [1:0]        aluop;
        logic              branch;
        logic              jump;
        logic              regwrite;
        logic              memtoreg;
        logic [2:0]        memread;
        logic [1:0]        memwrite;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } idex_t;

    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic [2:0]        memread;
        logic [1:0]        memwrite;
        logic [REG_AW-1:0] rd;
    } exmem_t;

    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic [REG_AW-1:0] rd;
    } memwb_t;

    localparam idex_t IDEX_BUBBLE = '{alusrc: 1'b0, aluop: 2'b00, branch: 1'b0,
                                      jump: 1'b0, regwrite: 1'b0, memtoreg: 1'b0,
                                      memread: MR_NONE, memwrite: MW_NONE,
                                      rd: '0, rs1: '0, rs2: '0};
    localparam exmem_t EXMEM_BUBBLE = '{regwrite: 1'b0, memtoreg: 1'b0,
                                        memread: MR_NONE, memwrite: MW_NONE, rd: '0};
    localparam memwb_t MEMWB_BUBBLE = '{regwrite: 1'b0, memtoreg: 1'b0, rd: '0};

    idex_t  idex_reg, idex_next, dec_bundle;
    exmem_t exmem_reg;
    memwb_t memwb_reg;
    logic   dec_legal;
    logic   load_use;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rd_f, rs1_f, rs2_f;
    logic              unused_funct7;

    assign opcode        = id_instr[6:0];
    assign funct3        = id_instr[14:12];
    assign rd_f          = REG_AW'(id_instr[11:7]);
    assign rs1_f         = REG_AW'(id_instr[19:15]);
    assign rs2_f         = REG_AW'(id_instr[24:20]);
    assign unused_funct7 = ^id_instr[31:25];

    // ---------------------------------------------------------------- decode
    always_comb begin
        dec_bundle = IDEX_BUBBLE;
        dec_legal  = 1'b0;
        case (opcode)
            OP_R: begin
                dec_legal           = 1'b1;
                dec_bundle.aluop    = 2'b10;
                dec_bundle.regwrite = 1'b1;
                dec_bundle.rs2      = rs2_f;
            end
            OP_IMM: begin
                dec_legal           = 1'b1;
                dec_bundle.alusrc   = 1'b1;
                dec_bundle.aluop    = 2'b10;
                dec_bundle.regwrite = 1'b1;
            end
            OP_LOAD: begin
                dec_legal           = 1'b1;
                dec_bundle.alusrc   = 1'b1;
                dec_bundle.regwrite = 1'b1;
                dec_bundle.memtoreg = 1'b1;
                case (funct3)
                    3'b000:  dec_bundle.memread = 3'b011;  // LB
                    3'b001:  dec_bundle.memread = 3'b001;  // LH
                    3'b010:  dec_bundle.memread = 3'b000;  // LW
                    3'b100:  dec_bundle.memread = 3'b100;  // LBU
                    3'b101:  dec_bundle.memread = 3'b010;  // LHU
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_STORE: begin
                dec_legal         = 1'b1;
                dec_bundle.alusrc = 1'b1;
                dec_bundle.rs2    = rs2_f;
                case (funct3)
                    3'b000:  dec_bundle.memwrite = 2'b10;  // SB
                    3'b001:  dec_bundle.memwrite = 2'b01;  // SH
                    3'b010:  dec_bundle.memwrite = 2'b00;  // SW
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_BRANCH: begin
                dec_legal         = 1'b1;
                dec_bundle.aluop  = 2'b01;
                dec_bundle.branch = 1'b1;
                dec_bundle.rs2    = rs2_f;
            end
            OP_LUI, OP_AUIPC: begin
                dec_legal           = 1'b1;
                dec_bundle.alusrc   = 1'b1;
                dec_bundle.regwrite = 1'b1;
            end
            OP_JAL: begin
                if (ENABLE_JUMP) begin
                    dec_legal           = 1'b1;
                    dec_bundle.aluop    = 2'b11;
                    dec_bundle.jump     = 1'b1;
                    dec_bundle.regwrite = 1'b1;
                end
            end
            OP_JALR: begin
                if (ENABLE_JUMP) begin
                    dec_legal           = 1'b1;
                    dec_bundle.alusrc   = 1'b1;
                    dec_bundle.aluop    = 2'b11;
                    dec_bundle.jump     = 1'b1;
                    dec_bundle.regwrite = 1'b1;
                end
            end
            default: dec_legal = 1'b0;
        endcase

        if (dec_legal) begin
            dec_bundle.rd  = rd_f;
            dec_bundle.rs1 = rs1_f;
            // x0 is hard-wired; never claim a write to it, so it can
            // never produce a forwarding or load-use match either.
            if (rd_f == '0) begin
                dec_bundle.regwrite = 1'b0;
            end
        end else begin
            dec_bundle = IDEX_BUBBLE;
        end
    end

    assign id_illegal = id_valid & ~dec_legal;

    // --------------------------------------------------------------- hazards
    // rs2 is already zeroed when the instruction does not read it, and ex
    // rd is required non-zero, so a plain compare covers the "rs2 used" case.
    assign load_use = id_valid && (idex_reg.memread != MR_NONE) && (idex_reg.rd != '0) &&
                      ((idex_reg.rd == dec_bundle.rs1) || (idex_reg.rd == dec_bundle.rs2));

    assign flush = (idex_reg.branch & ex_branch_taken) | idex_reg.jump;
    assign stall = load_use & ~flush;

    always_comb begin
        idex_next = dec_bundle;
        if (flush || stall || !id_valid) begin
            idex_next = IDEX_BUBBLE;
        end
    end

    // ------------------------------------------------------- stage registers
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_reg  <= IDEX_BUBBLE;
            exmem_reg <= EXMEM_BUBBLE;
            memwb_reg <= MEMWB_BUBBLE;
        end else begin
            idex_reg  <= idex_next;
            exmem_reg <= '{regwrite: idex_reg.regwrite, memtoreg: idex_reg.memtoreg,
                           memread: idex_reg.memread, memwrite: idex_reg.memwrite,
                           rd: idex_reg.rd};
            memwb_reg <= '{regwrite: exmem_reg.regwrite, memtoreg: exmem_reg.memtoreg,
                           rd: exmem_reg.rd};
        end
    end

    // ------------------------------------------------------------ forwarding
    // Index 0 is the rs1 operand, index 1 the rs2 operand. MEM wins over WB
    // because it holds the younger result.
    logic [1:0][REG_AW-1:0] ex_src;
    logic [1:0][1:0]        fwd_sel;

    assign ex_src = {idex_reg.rs2, idex_reg.rs1};

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        assign fwd_sel[gi] = (exmem_reg.regwrite && (exmem_reg.rd == ex_src[gi])) ? 2'b10 :
                             (memwb_reg.regwrite && (memwb_reg.rd == ex_src[gi])) ? 2'b01 :
                                                                                    2'b00;
    end

    assign fwd_a = fwd_sel[0];
    assign fwd_b = fwd_sel[1];

    // --------------------------------------------------------------- outputs
    assign ex_alusrc    = idex_reg.alusrc;
    assign ex_aluop     = idex_reg.aluop;
    assign ex_branch    = idex_reg.branch;
    assign ex_jump      = idex_reg.jump;
    assign mem_memread  = exmem_reg.memread;
    assign mem_memwrite = exmem_reg.memwrite;
    assign wb_regwrite  = memwb_reg.regwrite;
    assign wb_memtoreg  = memwb_reg.memtoreg;
    assign wb_rd        = memwb_reg.rd;

endmodule
